// File: rtl/sif_arb_pkg.sv
// Shared types and helpers for the streaming round-robin arbiter.
package sif_arb_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req searching upward from ptr+1, wrapping at num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int unsigned          num_req);
    rr_pick_t           r;
    logic [MAX_IDX_W:0] c;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 1; k <= num_req; k++) begin
      c = {1'b0, ptr} + (MAX_IDX_W+1)'(k);
      if (c >= (MAX_IDX_W+1)'(num_req)) c = c - (MAX_IDX_W+1)'(num_req);
      if (!r.found && req[c[MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sif_skid_buf.sv
// Two-entry registered valid/ready buffer; in_rdy is a flop, so no
// combinational path from out_rdy back to in_rdy.
module sif_skid_buf #(
  parameter int unsigned DMA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [DMA_WIDTH-1:0] in_dat,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [DMA_WIDTH-1:0] out_dat
);

  logic [1:0]           count_q, count_d;
  logic [DMA_WIDTH-1:0] head_q, head_d;
  logic [DMA_WIDTH-1:0] tail_q, tail_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 push, pop;

  assign push    = in_vld && in_rdy_q;
  assign pop     = out_vld && out_rdy;
  assign out_vld = (count_q != 2'd0);
  assign out_dat = head_q;
  assign in_rdy  = in_rdy_q;

  // Next occupancy and entry contents; head is always the oldest beat.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_dat;
        else                 tail_d = in_dat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_dat;
        end else begin
          head_d = tail_q;
          tail_d = in_dat;
        end
      end
      default: ;
    endcase
    in_rdy_d = (count_d != 2'd2);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      in_rdy_q <= in_rdy_d;
    end
  end

endmodule

// File: rtl/sif_rr_arb.sv
// Round-robin, burst-granular arbiter sharing one stream among NUM_REQ sources.
module sif_rr_arb
  import sif_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DMA_WIDTH = 64,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*DMA_WIDTH-1:0]   req_dat,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic                           dn_vld,
  output logic [DMA_WIDTH-1:0]           dn_dat,
  input  logic                           dn_rdy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  rr_pick_t             pick;
  logic                 pick_ok;
  logic                 hs;
  logic                 skid_in_vld, skid_in_rdy;
  logic [DMA_WIDTH-1:0] skid_in_dat;

  assign skid_in_vld = (state_q == GRANT) && req_vld[grant_q];
  assign skid_in_dat = req_dat[int'(grant_q)*DMA_WIDTH +: DMA_WIDTH];
  assign hs          = skid_in_vld && skid_in_rdy;
  assign req_rdy     = ((state_q == GRANT) && skid_in_rdy) ? (NUM_REQ'(1) << grant_q) : '0;
  assign grant_id    = grant_q;
  assign busy        = (state_q == GRANT) || dn_vld;

  // Arbitration decision and burst accounting.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(MAX_REQ'(req_vld), MAX_IDX_W'(rr_q), NUM_REQ);
    pick_ok = pick.found && ({1'b0, pick.idx} < (MAX_IDX_W+1)'(NUM_REQ));
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d = IDX_W'(pick.idx);
          rr_d    = IDX_W'(pick.idx);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) state_d = IDLE;
        end else if (!req_vld[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  sif_skid_buf #(
    .DMA_WIDTH (DMA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (skid_in_vld),
    .in_rdy  (skid_in_rdy),
    .in_dat  (skid_in_dat),
    .out_vld (dn_vld),
    .out_rdy (dn_rdy),
    .out_dat (dn_dat)
  );

endmodule

// File: tb/tb_sif_rr_arb.sv
// Bench for sif_rr_arb: directed scenarios plus randomized traffic checked by
// per-source scoreboards and rule-derived expectations.
module tb_sif_rr_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned MB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld;
  logic [NR*DW-1:0]  req_dat;
  logic [NR-1:0]     req_rdy;
  logic              dn_vld;
  logic [DW-1:0]     dn_dat;
  logic              dn_rdy;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  sif_rr_arb #(.NUM_REQ(NR), .DMA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_dat  (req_dat),
    .req_rdy  (req_rdy),
    .dn_vld   (dn_vld),
    .dn_dat   (dn_dat),
    .dn_rdy   (dn_rdy),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] srcq [NR][$];
  logic [DW-1:0] sbq  [NR][$];
  int            hs_src[$];
  int            hs_cyc[$];
  int            dn_cyc[$];
  logic          busy_log [64];
  logic [1:0]    gid_log  [64];
  int            cyc;
  int            delivered;
  int            rdy2_cnt;
  bit            rand_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_dat(input int src, input int seq);
    logic [31:0] r;
    r = $urandom;
    return {8'(src), 24'(seq), r};
  endfunction

  task automatic load(input int src, input int n);
    for (int k = 0; k < n; k++) srcq[src].push_back(mk_dat(src, k));
  endtask

  // Requester behaviour: hold valid until accepted, otherwise present next beat.
  task automatic drive(input logic [NR-1:0] uhs);
    for (int i = 0; i < NR; i++) begin
      if (!(req_vld[i] && !uhs[i])) begin
        req_vld[i] = (srcq[i].size() > 0) && (!rand_mode || ($urandom_range(3) != 0));
      end
      req_dat[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    if (rand_mode) dn_rdy = 1'($urandom_range(1));
  endtask

  task automatic tick();
    logic [NR-1:0] uhs;
    logic          dhs;
    logic [DW-1:0] dd;
    logic [DW-1:0] exp;
    int            s;
    @(negedge clk);
    uhs = req_vld & req_rdy;
    dhs = dn_vld && dn_rdy;
    dd  = dn_dat;
    chk("rdy_onehot", 64'($countones(req_rdy) <= 1), 64'd1);
    if (req_rdy != '0) chk("rdy_gid", 64'(req_rdy), 64'(4'd1 << grant_id));
    if (cyc < 64) begin
      busy_log[cyc] = busy;
      gid_log[cyc]  = grant_id;
    end
    if (cyc >= 3 && req_rdy[2]) rdy2_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (uhs[i]) begin
        sbq[i].push_back(srcq[i].pop_front());
        hs_src.push_back(i);
        hs_cyc.push_back(cyc);
      end
    end
    if (dhs) begin
      s = int'(dd[DW-1:DW-8]);
      if (s < NR && sbq[s].size() > 0) exp = sbq[s].pop_front();
      else exp = ~dd;
      chk("dn_order", dd, exp);
      dn_cyc.push_back(cyc);
      delivered++;
    end
    cyc++;
    drive(uhs);
  endtask

  task automatic clear_logs();
    cyc = 0;
    delivered = 0;
    rdy2_cnt = 0;
    hs_src.delete();
    hs_cyc.delete();
    dn_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_mode = 1'b0;
    for (int i = 0; i < NR; i++) begin
      srcq[i].delete();
      sbq[i].delete();
    end
    req_vld = '0;
    req_dat = '0;
    dn_rdy  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    req_vld = '0;
    req_dat = '0;
    dn_rdy = 1'b1;
    rand_mode = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_dn_vld", 64'(dn_vld), 64'd0);
    chk("rst_dn_dat", dn_dat, 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single requester 1, three beats, latency and busy fall.
    load(1, 3);
    drive('0);
    for (int k = 0; k < 8; k++) tick();
    chk("t1_count", 64'(dn_cyc.size()), 64'd3);
    for (int k = 0; k < 3 && k < dn_cyc.size(); k++) chk("t1_dn_cycle", 64'(dn_cyc[k]), 64'(k + 2));
    chk("t1_grant_id", 64'(gid_log[1]), 64'd1);
    chk("t1_busy_c4", 64'(busy_log[4]), 64'd1);
    chk("t1_busy_c5", 64'(busy_log[5]), 64'd0);

    // All requesters continuously valid: rotation with one bubble per burst.
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 40);
    drive('0);
    for (int k = 0; k < 50; k++) tick();
    chk("t2_hs_count", 64'(hs_src.size() >= 40), 64'd1);
    for (int k = 0; k < 40 && k < hs_src.size(); k++) begin
      chk("t2_src", 64'(hs_src[k]), 64'((k / MB) % NR));
      if (k > 0) chk("t2_gap", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'((k % MB == 0) ? 2 : 1));
    end

    // Downstream stall: two beats accepted, then nothing until dn_rdy returns.
    do_reset();
    dn_rdy = 1'b0;
    load(2, 6);
    drive('0);
    for (int k = 0; k < 10; k++) tick();
    chk("t3_stall_hs", 64'(hs_src.size()), 64'd2);
    chk("t3_rdy_low", 64'(rdy2_cnt), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_grant", 64'(grant_id), 64'd2);
    dn_rdy = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    chk("t3_delivered", 64'(delivered), 64'd6);
    chk("t3_left", 64'(sbq[2].size() + srcq[2].size()), 64'd0);

    // Requester 0 stops after 3 beats while 3 waits.
    do_reset();
    load(0, 3);
    load(3, 4);
    drive('0);
    for (int k = 0; k < 14; k++) tick();
    chk("t4_hs_count", 64'(hs_src.size()), 64'd7);
    if (hs_src.size() >= 4) begin
      chk("t4_first_cyc", 64'(hs_cyc[0]), 64'd1);
      for (int k = 0; k < 3; k++) chk("t4_src0", 64'(hs_src[k]), 64'd0);
      chk("t4_src3", 64'(hs_src[3]), 64'd3);
      chk("t4_switch_cyc", 64'(hs_cyc[3]), 64'(hs_cyc[2] + 3));
    end

    // Reset mid-burst with two beats buffered.
    do_reset();
    dn_rdy = 1'b0;
    load(1, 8);
    drive('0);
    for (int k = 0; k < 5; k++) tick();
    dn_rdy = 1'b1;
    tick();
    dn_rdy = 1'b0;
    tick();
    chk("t5_pre_hs", 64'(hs_src.size()), 64'd3);
    chk("t5_pre_vld", 64'(dn_vld), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_dn_vld", 64'(dn_vld), 64'd0);
    chk("t5_req_rdy", 64'(req_rdy), 64'd0);
    chk("t5_grant_id", 64'(grant_id), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NR; i++) begin
      srcq[i].delete();
      sbq[i].delete();
    end
    req_vld = '0;
    dn_rdy = 1'b1;
    clear_logs();
    load(2, 2);
    load(3, 2);
    drive('0);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_first_src", 64'((hs_src.size() > 0) ? hs_src[0] : -1), 64'd2);
    chk("t5_delivered", 64'(delivered), 64'd4);

    // Randomized traffic and backpressure, 1000 tagged beats.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < NR; i++) load(i, 250);
    drive('0);
    guard = 0;
    while (delivered < 1000 && guard < 20000) begin
      tick();
      guard++;
    end
    rand_mode = 1'b0;
    dn_rdy = 1'b1;
    chk("t6_delivered", 64'(delivered), 64'd1000);
    chk("t6_left", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() +
                       srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
